mem_bus_responder: RTL and testbench

//  Memory-side responder for the processor address bus. Accepts one access

---
 rtl/mem_bus_responder.sv | 127 ++++++++++++
 tb/tb_mem_bus_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// Memory-side responder for the processor address bus: serves one fetch, LDR or
// STR at a time with a fixed wait-state count and routes read data to its consumer.
module mem_bus_responder #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_data,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] address_add_bus_in,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic              instr_valid,
    output logic [DATA_W-1:0] ldr_data,
    output logic              ldr_valid,
    output logic              str_done,
    output logic              busy
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESPOND
    } state_t;

    typedef enum logic [1:0] {
        KIND_FETCH,
        KIND_LDR,
        KIND_STR
    } kind_t;

    state_t           state;
    kind_t            kind;
    kind_t            req_kind_c;
    logic [CNT_W-1:0] cnt;

    // A fetch never writes, whatever req_write says.
    always_comb begin
        req_kind_c = KIND_FETCH;
        if (req_is_data) begin
            req_kind_c = req_write ? KIND_STR : KIND_LDR;
        end
    end

    // Request FSM; strobes and response pulses are registered so reset clears them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            kind        <= KIND_FETCH;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            ldr_data    <= '0;
            ldr_valid   <= 1'b0;
            str_done    <= 1'b0;
            busy        <= 1'b0;
            req_ready   <= 1'b1;
        end else begin
            instr_valid <= 1'b0;
            ldr_valid   <= 1'b0;
            str_done    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        kind      <= req_kind_c;
                        mem_addr  <= address_add_bus_in;
                        mem_wdata <= req_wdata;
                        cnt       <= CNT_W'(WAIT_CYCLES);
                        mem_re    <= (req_kind_c != KIND_STR);
                        mem_we    <= (req_kind_c == KIND_STR);
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        mem_re <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= ST_RESPOND;
                        case (kind)
                            KIND_FETCH: begin
                                instr_out   <= mem_rdata;
                                instr_valid <= 1'b1;
                            end
                            KIND_LDR: begin
                                ldr_data  <= mem_rdata;
                                ldr_valid <= 1'b1;
                            end
                            default: str_done <= 1'b1;
                        endcase
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESPOND: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    mem_re    <= 1'b0;
                    mem_we    <= 1'b0;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: one instance with 2 wait states (index 0)
// and one with 0 wait states (index 1) sharing request fields, memory data and reset.
module tb_mem_bus_responder;

    typedef struct {
        logic [2:0]  pulses;   // {instr_valid, ldr_valid, str_done}
        logic [31:0] instr;
        logic [31:0] ldr;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [2];
    logic        req_is_data;
    logic        req_write;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic        ready [2];
    logic        re    [2];
    logic        we    [2];
    logic        iv    [2];
    logic        lv    [2];
    logic        sd    [2];
    logic        busy  [2];
    logic [15:0] maddr [2];
    logic [31:0] mwd   [2];
    logic [31:0] iout  [2];
    logic [31:0] ld    [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] exp_instr [2];
    logic [31:0] exp_ldr   [2];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_responder #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(ready[0]),
        .req_is_data(req_is_data), .req_write(req_write), .address_add_bus_in(addr),
        .req_wdata(wdata), .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_re(re[0]),
        .mem_we(we[0]), .mem_rdata(rdata), .instr_out(iout[0]), .instr_valid(iv[0]),
        .ldr_data(ld[0]), .ldr_valid(lv[0]), .str_done(sd[0]), .busy(busy[0])
    );

    mem_bus_responder #(.ADDR_W(16), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(ready[1]),
        .req_is_data(req_is_data), .req_write(req_write), .address_add_bus_in(addr),
        .req_wdata(wdata), .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_re(re[1]),
        .mem_we(we[1]), .mem_rdata(rdata), .instr_out(iout[1]), .instr_valid(iv[1]),
        .ldr_data(ld[1]), .ldr_valid(lv[1]), .str_done(sd[1]), .busy(busy[1])
    );

    function automatic int wc(input int d);
        return (d == 1) ? 0 : 2;
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h", name, d, act, exp);
        end
    endtask

    // Pops the expected response whenever an instance presents a pulse.
    task automatic mon(input int d);
        exp_t e;
        if (iv[d] || lv[d] || sd[d]) begin
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_resp (dut%0d): pulses %b with nothing pending",
                         d, {iv[d], lv[d], sd[d]});
            end else begin
                e = (d == 1) ? q1.pop_front() : q0.pop_front();
                chk(d, "resp_pulses", 32'({iv[d], lv[d], sd[d]}), 32'(e.pulses));
                chk(d, "instr_out", iout[d], e.instr);
                chk(d, "ldr_data", ld[d], e.ldr);
                chk(d, "resp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0);
            mon(1);
        end
    end

    // Presents a request, waits for acceptance and queues the expected response.
    task automatic issue(input int d, input logic is_data, input logic write, input logic [15:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, output int acc);
        exp_t e;
        int   n;
        req_is_data  = is_data;
        req_write    = write;
        addr         = a;
        wdata        = wd;
        rdata        = rd;
        req_valid[d] = 1'b1;
        n = 0;
        while (!ready[d] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout (dut%0d): req_ready never rose", d);
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        acc = cyc;
        if (!is_data) begin
            exp_instr[d] = rd;
            e.pulses     = 3'b100;
        end else if (write) begin
            e.pulses = 3'b001;
        end else begin
            exp_ldr[d] = rd;
            e.pulses   = 3'b010;
        end
        e.instr = exp_instr[d];
        e.ldr   = exp_ldr[d];
        e.cyc   = acc + wc(d) + 1;
        if (d == 1) q1.push_back(e);
        else        q0.push_back(e);
    endtask

    // Strobes high for wait+1 cycles, then one low RESPOND cycle; address/data held throughout.
    task automatic check_access(input int d, input logic [15:0] a, input logic [31:0] wd, input logic is_str);
        for (int i = 0; i <= wc(d) + 1; i++) begin
            @(negedge clk);
            chk(d, "mem_re", 32'(re[d]), 32'((i <= wc(d)) && !is_str));
            chk(d, "mem_we", 32'(we[d]), 32'((i <= wc(d)) && is_str));
            chk(d, "busy", 32'(busy[d]), 32'(1));
            chk(d, "req_ready", 32'(ready[d]), 32'(0));
            chk(d, "mem_addr", 32'(maddr[d]), 32'(a));
            chk(d, "mem_wdata", mwd[d], wd);
        end
    endtask

    task automatic reset_checks();
        for (int d = 0; d < 2; d++) begin
            chk(d, "rst_req_ready", 32'(ready[d]), 32'(1));
            chk(d, "rst_busy", 32'(busy[d]), 32'(0));
            chk(d, "rst_strobes", 32'({re[d], we[d]}), 32'(0));
            chk(d, "rst_pulses", 32'({iv[d], lv[d], sd[d]}), 32'(0));
            chk(d, "rst_mem_addr", 32'(maddr[d]), 32'(0));
            chk(d, "rst_mem_wdata", mwd[d], 32'(0));
            chk(d, "rst_instr_out", iout[d], 32'(0));
            chk(d, "rst_ldr_data", ld[d], 32'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int rel;
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b0;
        req_is_data  = 1'b0;
        req_write    = 1'b0;
        addr         = '0;
        wdata        = '0;
        rdata        = '0;
        for (int d = 0; d < 2; d++) begin
            exp_instr[d] = '0;
            exp_ldr[d]   = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset asserted mid-cycle, outputs checked before the next edge
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        reset_checks();
        @(negedge clk);
        rst = 1'b0;

        // FETCH, STR, LDR, then a second FETCH to show ldr_data holds
        issue(0, 1'b0, 1'b0, 16'h0042, 32'h0000_0000, 32'hDEAD_BEEF, acc);
        check_access(0, 16'h0042, 32'h0000_0000, 1'b0);
        issue(0, 1'b1, 1'b1, 16'h1234, 32'hCAFE_F00D, 32'h0000_0000, acc);
        check_access(0, 16'h1234, 32'hCAFE_F00D, 1'b1);
        issue(0, 1'b1, 1'b0, 16'h00FF, 32'h0000_0000, 32'h0000_A5A5, acc);
        check_access(0, 16'h00FF, 32'h0000_0000, 1'b0);
        issue(0, 1'b0, 1'b0, 16'h0043, 32'h0000_0001, 32'h1234_5678, acc);
        check_access(0, 16'h0043, 32'h0000_0001, 1'b0);

        // Request held while busy, reset in the second ACCESS cycle
        issue(0, 1'b0, 1'b0, 16'h0300, 32'h0000_0000, 32'h1111_2222, acc);
        req_is_data  = 1'b1;
        req_write    = 1'b1;
        addr         = 16'h0200;
        wdata        = 32'h0BAD_F00D;
        req_valid[0] = 1'b1;
        @(negedge clk);
        chk(0, "abort_mem_re_before", 32'(re[0]), 32'(1));
        @(negedge clk);
        chk(0, "held_not_accepted", 32'(ready[0]), 32'(0));
        rst = 1'b1;
        #1;
        chk(0, "abort_strobes", 32'({re[0], we[0]}), 32'(0));
        chk(0, "abort_busy", 32'(busy[0]), 32'(0));
        chk(0, "abort_req_ready", 32'(ready[0]), 32'(1));
        chk(0, "abort_instr_out", iout[0], 32'(0));
        chk(0, "abort_ldr_data", ld[0], 32'(0));
        q0.delete();
        for (int d = 0; d < 2; d++) begin
            exp_instr[d] = '0;
            exp_ldr[d]   = '0;
        end
        @(negedge clk);
        rst = 1'b0;
        rel = cyc;
        issue(0, 1'b1, 1'b1, 16'h0200, 32'h0BAD_F00D, 32'h0000_0000, acc);
        chk(0, "held_accept_cycle", 32'(acc), 32'(rel + 1));
        check_access(0, 16'h0200, 32'h0BAD_F00D, 1'b1);

        // Zero wait states: fetch with req_write=1 stays a read; then back-to-back LDR
        issue(1, 1'b0, 1'b1, 16'h0077, 32'h55AA_55AA, 32'h1357_9BDF, acc);
        check_access(1, 16'h0077, 32'h55AA_55AA, 1'b0);
        issue(1, 1'b1, 1'b0, 16'hFFFF, 32'h0000_0000, 32'hFFFF_0000, acc);
        check_access(1, 16'hFFFF, 32'h0000_0000, 1'b0);

        repeat (4) @(negedge clk);
        chk(0, "pending_responses", 32'(q0.size()), 32'(0));
        chk(1, "pending_responses", 32'(q1.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
